// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S stereo transmitter with a one-deep pending sample register
// A BCLK divider sets the slot timing; a 32-bit shifter is reloaded once per frame.
module i2s_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iValid,
    input  logic [15:0] iLeft,
    input  logic [15:0] iRight,
    output logic        oBclk,
    output logic        oLrclk,
    output logic        oSdata,
    output logic        oLoad,
    output logic        oUnderrun,
    output logic        oOverrun
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic [4:0]       b_q, b_d;
    logic             lrclk_q, lrclk_d;
    logic [31:0]      shifter_q, shifter_d;
    logic             pend_full_q, pend_full_d;
    logic [31:0]      pend_data_q, pend_data_d;
    logic [31:0]      last_frame_q, last_frame_d;
    logic             load_q, load_d;
    logic             underrun_q, underrun_d;
    logic             overrun_q, overrun_d;

    logic wrap;
    logic fall;
    logic load_fire;

    always_comb begin
        wrap         = (div_q == DIV_MAX);
        fall         = wrap && bclk_q;
        load_fire    = fall && (b_q == 5'd0);

        div_d        = wrap ? '0 : div_q + DIV_W'(1);
        bclk_d       = wrap ? ~bclk_q : bclk_q;
        b_d          = fall ? b_q + 5'd1 : b_q;
        // Word select switches at the start of slot 16, one BCLK ahead of the right MSB.
        lrclk_d      = fall ? b_d[4] : lrclk_q;

        shifter_d    = shifter_q;
        last_frame_d = last_frame_q;
        if (load_fire) begin
            if (pend_full_q) begin
                shifter_d    = pend_data_q;
                last_frame_d = pend_data_q;
            end else begin
                shifter_d    = last_frame_q;
            end
        end else if (fall) begin
            shifter_d = {shifter_q[30:0], 1'b0};
        end

        // The load consumes the pre-cycle pending value before a new sample lands.
        pend_full_d = pend_full_q && !load_fire;
        pend_data_d = pend_data_q;
        if (iValid) begin
            pend_full_d = 1'b1;
            pend_data_d = {iLeft, iRight};
        end

        load_d     = load_fire;
        underrun_d = load_fire && !pend_full_q;
        overrun_d  = iValid && pend_full_q && !load_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            bclk_q       <= 1'b0;
            b_q          <= 5'd0;
            lrclk_q      <= 1'b0;
            shifter_q    <= 32'd0;
            pend_full_q  <= 1'b0;
            pend_data_q  <= 32'd0;
            last_frame_q <= 32'd0;
            load_q       <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            div_q        <= div_d;
            bclk_q       <= bclk_d;
            b_q          <= b_d;
            lrclk_q      <= lrclk_d;
            shifter_q    <= shifter_d;
            pend_full_q  <= pend_full_d;
            pend_data_q  <= pend_data_d;
            last_frame_q <= last_frame_d;
            load_q       <= load_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
        end
    end

    assign oBclk     = bclk_q;
    assign oLrclk    = lrclk_q;
    assign oSdata    = shifter_q[31];
    assign oLoad     = load_q;
    assign oUnderrun = underrun_q;
    assign oOverrun  = overrun_q;

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Consumes filtered 16-bit signed audio samples, as produced by the output low-pass stage, and serialises them as a standard I2S stereo stream to an external DAC.
- Sits at the chip boundary, after the output filter; the filter's sample strobe drives iValid.
- A one-deep pending register decouples the sample rate from the I2S frame rate. Overrun and underrun are flagged.

Parameters:
- CLK_DIV, 4, clk cycles per BCLK half-period (legal values >= 2). Frame = 64*CLK_DIV clk cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- iValid  in  1  one-cycle sample strobe
- iLeft  in  16  signed left sample, captured when iValid=1
- iRight  in  16  signed right sample, captured when iValid=1
- oBclk  out  1  I2S bit clock
- oLrclk  out  1  I2S word select (0 = left slot)
- oSdata  out  1  I2S serial data, MSB first
- oLoad  out  1  one-cycle pulse when a frame is loaded into the shifter
- oUnderrun  out  1  one-cycle pulse when a frame loads with no pending sample
- oOverrun  out  1  one-cycle pulse when iValid overwrites an unconsumed pending sample

Behaviour:
- Reset values:
  - oBclk=0, oLrclk=0, oSdata=0, all pulses 0.
  - Divider=0, slot index b=0, shifter=0, pending empty, pending data=0, last frame=0.
- Divider:
  - Counts 0..CLK_DIV-1.
  - On wrap, oBclk toggles.
  - First rising edge occurs CLK_DIV cycles after reset release; first falling edge occurs 2*CLK_DIV cycles after reset release.
- Slot index b (0..31) advances, wrapping 31->0, on every cycle in which oBclk goes 1->0 (the "fall cycle"). oLrclk and oSdata update only in fall cycles, all registered.
- oLrclk = 0 for b in 0..15 and 1 for b in 16..31. It leads the data by one BCLK, per I2S.
- Data placement:
  - Left MSB..LSB occupy b=1..16.
  - Right MSB..LSB occupy b=17..31, with the right LSB in b=0 of the following frame.
  - oSdata = shifter[31]. The shifter shifts left, zero-filled, each fall cycle.
- Frame load, in the fall cycle entering b=1:
  - Pending full: shifter <= {pendL,pendR}, last frame <= same, pending <= empty, oLoad=1.
  - Pending empty: shifter <= last frame (repeat), oLoad=1, oUnderrun=1.
- Pending write:
  - iValid=1 writes {iLeft,iRight} to pending and sets it full.
  - If pending was already full and is not being consumed in the same cycle, oOverrun=1. The new value replaces the old one.
- Simultaneous iValid and frame load: the load consumes the pre-cycle pending contents, then the new sample becomes pending with no overrun. If pending was empty before that cycle, the load is an underrun and the new sample waits for the next frame.
- The whole cycle from pulse assertion to deassertion is registered. The pulses assert in the cycle after the triggering event and last exactly one cycle.
- No arithmetic on samples: two's-complement bits are transmitted unchanged.
- rst asserted mid-frame: all state returns to reset values on the next clock and any pending sample is discarded. The stream restarts as after power-up.

Test Plan:
- Reset, CLK_DIV=4, no iValid -> oBclk period 8 clk; oLrclk period 256 clk, low for 128; oSdata stays 0; oUnderrun pulses once per frame at each load.
- Single iValid L=16'h8001, R=16'h7FFE before the first load -> the left slot (b=1..16) carries 1000000000000001 and the right slot carries 0111111111111110. oLoad pulses once, with no underrun on that frame.
- One sample, then none -> subsequent frames repeat 8001/7FFE identically; oUnderrun pulses each frame.
- Two iValids (A5A5/5A5A then 1234/FEDC) within one frame -> oOverrun pulses once; the next frame transmits 1234/FEDC.
- iValid in the exact load cycle with pending full (old 0001/0002, new 0003/0004) -> frame sends 0001/0002 with no overrun; the next frame sends 0003/0004.
- rst pulsed at b=20 mid-frame -> the outputs take reset values on the next clock; timing restarts with the first falling edge 2*CLK_DIV cycles after release; the pending sample is lost and the first load underruns.
